// File: rtl/booth_product_accumulator.sv
// Frame accumulator for Booth multiplier products: sums beats into a wide running sum and
// presents one registered result per frame. Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module booth_product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              clr,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  input  logic              acc_ready
);

`ifdef ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_p0, state_d;
  logic [ACC_W-1:0]   sum_p0, sum_d, base_sum;
  logic [CNT_W-1:0]   cnt_p0, cnt_d, base_cnt;
  logic               ovf_p0, ovf_d, base_ovf;
  logic [ACC_W:0]     sum_nx;
  logic               load_res;

  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    return {1'b0, a} + (ACC_W+1)'(p);
  endfunction

  // Carry out of the top bit either clamps to all-ones or is dropped (modulo wrap).
  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] s);
    return (SAT_EN && s[ACC_W]) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // clr wipes the frame first so a beat in the same cycle starts a fresh frame.
  assign base_sum   = clr ? '0   : sum_p0;
  assign base_cnt   = clr ? '0   : cnt_p0;
  assign base_ovf   = clr ? 1'b0 : ovf_p0;
  assign sum_nx     = add_ext(base_sum, prod_data);
  assign prod_ready = (state_p0 != HOLD);
  assign acc_valid  = (state_p0 == HOLD);

  always_comb begin
    state_d  = state_p0;
    sum_d    = sum_p0;
    cnt_d    = cnt_p0;
    ovf_d    = ovf_p0;
    load_res = 1'b0;
    case (state_p0)
      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        if (clr) begin
          state_d = IDLE;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
        if (prod_valid) begin
          sum_d = sat_sum(sum_nx);
          cnt_d = cnt_inc(base_cnt);
          ovf_d = base_ovf | sum_nx[ACC_W];
          if (prod_last) begin
            state_d  = HOLD;
            load_res = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
    endcase
  end

  // Stage 0: frame accumulation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      sum_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
    end else begin
      state_p0 <= state_d;
      sum_p0   <= sum_d;
      cnt_p0   <= cnt_d;
      ovf_p0   <= ovf_d;
    end
  end

  // Stage 1: result registers, loaded only on the edge that accepts the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data  <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else if (load_res) begin
      acc_data  <= sum_d;
      acc_count <= cnt_d;
      acc_ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: a default 40-bit instance and a 33-bit instance share stimulus
// and are checked against a frame-total reference model (honours ACC_SATURATE_EN).
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prod_valid = 1'b0;
  logic [31:0] prod_data = '0;
  logic        prod_last = 1'b0;
  logic        clr = 1'b0;
  logic        acc_ready = 1'b0;

  logic        prod_ready, acc_valid, acc_ovf;
  logic [39:0] acc_data;
  logic [7:0]  acc_count;
  logic        prod_ready33, acc_valid33, acc_ovf33;
  logic [32:0] acc_data33;
  logic [7:0]  acc_count33;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(prod_ready), .clr(clr), .acc_valid(acc_valid),
    .acc_data(acc_data), .acc_count(acc_count), .acc_ovf(acc_ovf), .acc_ready(acc_ready)
  );

  booth_product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut33 (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(prod_ready33), .clr(clr), .acc_valid(acc_valid33),
    .acc_data(acc_data33), .acc_count(acc_count33), .acc_ovf(acc_ovf33), .acc_ready(acc_ready)
  );

  // Reference model: a frame is the arithmetic total of its beats plus a beat count.
  logic        m_hold;
  logic [63:0] m_tot, r_tot, m_next;
  int          m_n, r_n;

  assign m_next = (clr ? 64'd0 : m_tot) + 64'(prod_data);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= 1'b0;
      m_tot  <= '0;
      m_n    <= 0;
      r_tot  <= '0;
      r_n    <= 0;
    end else if (m_hold) begin
      if (acc_ready) m_hold <= 1'b0;
    end else if (prod_valid) begin
      if (prod_last) begin
        r_tot  <= m_next;
        r_n    <= (clr ? 0 : m_n) + 1;
        m_hold <= 1'b1;
        m_tot  <= '0;
        m_n    <= 0;
      end else begin
        m_tot <= m_next;
        m_n   <= (clr ? 0 : m_n) + 1;
      end
    end else if (clr) begin
      m_tot <= '0;
      m_n   <= 0;
    end
  end

  function automatic logic [63:0] exp_sum(input logic [63:0] tot, input int w);
    logic [63:0] lim;
    lim = 64'd1 << w;
`ifdef ACC_SATURATE_EN
    return (tot >= lim) ? lim - 64'd1 : tot;
`else
    return tot & (lim - 64'd1);
`endif
  endfunction

  function automatic logic [63:0] exp_ovf(input logic [63:0] tot, input int w);
    return {63'd0, tot >= (64'd1 << w)};
  endfunction

  function automatic logic [63:0] exp_cnt(input int n);
    return (n > 255) ? 64'd255 : 64'(n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare both instances against the model at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("prod_ready",   64'(prod_ready),   64'(!m_hold));
    chk("prod_ready33", 64'(prod_ready33), 64'(!m_hold));
    chk("acc_valid",    64'(acc_valid),    64'(m_hold));
    chk("acc_valid33",  64'(acc_valid33),  64'(m_hold));
    if (m_hold) begin
      chk("acc_data",    64'(acc_data),    exp_sum(r_tot, 40));
      chk("acc_data33",  64'(acc_data33),  exp_sum(r_tot, 33));
      chk("acc_count",   64'(acc_count),   exp_cnt(r_n));
      chk("acc_count33", 64'(acc_count33), exp_cnt(r_n));
      chk("acc_ovf",     64'(acc_ovf),     exp_ovf(r_tot, 40));
      chk("acc_ovf33",   64'(acc_ovf33),   exp_ovf(r_tot, 33));
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    tick();
  endtask

  task automatic idle();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic handshake();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 64'(acc_data), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_count", 64'(acc_count), 64'd0);
    chk("rst_ovf",   64'(acc_ovf),   64'd0);

    // Back-to-back frame of three beats
    beat(32'h6, 1'b0);
    beat(32'hF, 1'b0);
    beat(32'h14, 1'b1);
    idle();
    chk("t1_valid", 64'(acc_valid), 64'd1);
    chk("t1_data",  64'(acc_data),  64'h29);
    chk("t1_count", 64'(acc_count), 64'd3);
    chk("t1_ovf",   64'(acc_ovf),   64'd0);
    prod_valid = 1'b1;
    prod_data  = 32'h77;
    repeat (2) tick();
    chk("t1_ready_hold", 64'(prod_ready), 64'd0);
    prod_valid = 1'b0;
    handshake();

    // Single-term frame held while the sink stalls
    beat(32'hFFFE0001, 1'b1);
    idle();
    repeat (5) begin
      tick();
      chk("t2_data_stable", 64'(acc_data), 64'hFFFE0001);
    end
    chk("t2_count", 64'(acc_count), 64'd1);
    handshake();
    chk("t2_valid_drop", 64'(acc_valid), 64'd0);
    chk("t2_ready_back", 64'(prod_ready), 64'd1);

    // Carry out of a 33-bit accumulator
    beat(32'hFFFE0001, 1'b0);
    beat(32'hFFFE0001, 1'b0);
    beat(32'hFFFE0001, 1'b1);
    idle();
`ifdef ACC_SATURATE_EN
    chk("t3_data33", 64'(acc_data33), 64'h1FFFFFFFF);
`else
    chk("t3_data33", 64'(acc_data33), 64'h0FFFA0003);
`endif
    chk("t3_ovf33",  64'(acc_ovf33), 64'd1);
    chk("t3_data40", 64'(acc_data),  64'h2FFFA0003);
    chk("t3_ovf40",  64'(acc_ovf),   64'd0);
    handshake();

    // clr with a same-cycle last beat, then clr ignored in HOLD
    beat(32'h10, 1'b0);
    beat(32'h20, 1'b0);
    clr = 1'b1;
    beat(32'h5, 1'b1);
    idle();
    chk("t4_data",  64'(acc_data),  64'h5);
    chk("t4_count", 64'(acc_count), 64'd1);
    clr = 1'b1;
    repeat (2) tick();
    clr = 1'b0;
    chk("t4_hold_data", 64'(acc_data), 64'h5);
    handshake();

    // Reset during ACCUM
    beat(32'h7, 1'b0);
    beat(32'h8, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t5_accum_rst_data",  64'(acc_data),  64'd0);
    chk("t5_accum_rst_count", 64'(acc_count), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Reset during HOLD
    beat(32'h9, 1'b1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t5_hold_rst_valid", 64'(acc_valid), 64'd0);
    chk("t5_hold_rst_data",  64'(acc_data),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    beat(32'h3, 1'b1);
    idle();
    chk("t5_after_data",  64'(acc_data),  64'h3);
    chk("t5_after_count", 64'(acc_count), 64'd1);
    handshake();

    // Count saturation over a long frame
    for (int i = 0; i < 300; i++) beat(32'h1, 1'b0);
    beat(32'h1, 1'b1);
    idle();
    chk("t6_count", 64'(acc_count), 64'd255);
    chk("t6_data",  64'(acc_data),  64'h12D);
    chk("t6_ovf",   64'(acc_ovf),   64'd0);
    handshake();

    // prod_last without prod_valid must not close a frame
    prod_last = 1'b1;
    tick();
    chk("t7_last_no_valid", 64'(acc_valid), 64'd0);
    idle();

    // Randomised traffic with stalls and occasional clr
    for (int i = 0; i < 600; i++) begin
      prod_valid = ($urandom_range(3) != 0);
      prod_data  = $urandom;
      prod_last  = ($urandom_range(5) == 0);
      clr        = ($urandom_range(19) == 0);
      acc_ready  = ($urandom_range(2) != 0);
      tick();
    end
    idle();
    acc_ready = 1'b1;
    repeat (3) tick();
    acc_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Downstream consumer of the 16x16 unsigned Booth multiplier's 32-bit product.
- Sums a frame of products (dot-product / MAC style) into a wide running sum, with a valid/ready handshake on each side.
- Presents one registered result per frame, plus a term count and an overflow flag.
- Sits between the combinational multiplier array and the result sink/register file.

Parameters:
- PROD_W, 32, width of incoming product (multiplier output width).
- ACC_W, 40, running-sum/result width; must be >= PROD_W.
- CNT_W, 8, width of term counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prod_valid  input  1  upstream product beat valid.
- prod_data  input  PROD_W  unsigned product from multiplier.
- prod_last  input  1  marks final beat of a frame; qualified by prod_valid.
- prod_ready  output  1  block can accept a beat this cycle.
- clr  input  1  synchronous discard of in-progress frame.
- acc_valid  output  1  result registers valid.
- acc_data  output  ACC_W  frame sum.
- acc_count  output  CNT_W  number of beats in frame.
- acc_ovf  output  1  sum exceeded ACC_W bits during frame (sticky per frame).
- acc_ready  input  1  downstream accepts result.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, sum=0, count=0, ovf=0, acc_valid=0, acc_data=0, acc_count=0, acc_ovf=0. prod_ready=1 one cycle after reset deassertion (combinational from state).
- Beat accepted iff prod_valid && prod_ready at the clock edge. prod_ready = (state != HOLD).
- Arithmetic: next_sum = sum + zero-extend(prod_data) in ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets ovf (sticky until frame start).
  - Without the optional feature, the sum wraps modulo 2^ACC_W.
- count increments per accepted beat and saturates at 2^CNT_W-1 (no wrap). Count saturation does not set ovf.

State machine:
- IDLE: sum=0, count=0, ovf=0.
  - Accepted beat, no last -> ACCUM.
  - Accepted beat with last -> HOLD; single-term result = prod_data, count=1.
- ACCUM: one or more beats held.
  - Accepted beat, no last -> stay.
  - Accepted beat with last -> HOLD.
- HOLD: entered on the edge that accepts the last beat. acc_valid=1 in the following cycle.
  - acc_data/acc_count/acc_ovf are loaded from the final next_sum/count/ovf and are stable while acc_valid=1.
  - On acc_valid && acc_ready -> IDLE. acc_valid=0 next cycle; sum/count/ovf are cleared.
  - prod_ready=0 throughout HOLD, giving a minimum 1-cycle bubble between frames.

Latency and timing:
- Last beat accepted at edge N -> acc_valid high after edge N.
- Throughput: 1 beat/cycle within a frame.
- acc_valid is never dropped without acc_ready.

clr:
- In IDLE/ACCUM: sum, count and ovf are cleared; state -> IDLE.
- If a beat is accepted the same cycle, clr takes priority, then the beat is loaded as the first term of a new frame. State -> ACCUM, or -> HOLD if prod_last.
- In HOLD, clr is ignored; a pending result is never lost.

Other boundary rules:
- prod_last without prod_valid is ignored.
- Reset mid-frame or mid-HOLD discards everything and returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: on carry out, sum clamps to 2^ACC_W-1 and remains there for the rest of the frame. ovf is still set.
- Undefined: modulo-2^ACC_W wrap; ovf is set on carry.
- Port list is identical in both builds.

Test Plan:
- Reset then beats 0x00000006, 0x0000000F, 0x00000014(last), back-to-back -> one cycle after last: acc_valid=1, acc_data=0x29, acc_count=3, acc_ovf=0; prod_ready=0 until acc_ready.
- Single beat 0xFFFE0001 with last, acc_ready held low 5 cycles -> acc_data=0xFFFE0001, count=1, held stable 5 cycles; acc_ready=1 -> acc_valid=0 next cycle, prod_ready=1.
- ACC_W=33, three beats of 0xFFFE0001 -> no macro: acc_data=0x0FFFA0003, acc_ovf=1; ACC_SATURATE_EN: acc_data=0x1FFFFFFFF, acc_ovf=1.
- Beats 0x10, 0x20, then clr with beat 0x5(last) same cycle -> acc_data=0x5, acc_count=1; clr asserted in HOLD -> result unchanged.
- 300 beats of 0x1 then last -> acc_count=255 (saturated), acc_data=301 (0x12D), acc_ovf=0.
- rst_n low during ACCUM (after 2 beats) and during HOLD -> outputs zero asynchronously; the next frame of 0x3 (last) yields acc_data=0x3, count=1.
